// File: rtl/robs_control.sv
// Sequencer for the signed Robertson multiplier datapath: drives the 15-bit control word.
// Optional build macro ROBS_CTRL_DONE_HOLD_EN keeps done high until start is released.
module robs_control #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        zr,
  input  logic        zq,
  output logic [14:0] c,
  output logic        busy,
  output logic        done
);

  // zq flags q == 0 mod 8, so the datapath only works for 8-bit operands.
  if (WIDTH != 8) begin : g_width_check
    $error("robs_control supports WIDTH == 8 only");
  end

  localparam int C_LD_Y    = 0;
  localparam int C_PRE_Q   = 1;
  localparam int C_CLR_A   = 2;
  localparam int C_LD_X    = 3;
  localparam int C_RLO_SEL = 6;
  localparam int C_X_SEL   = 7;
  localparam int C_LD_RHI  = 8;
  localparam int C_LD_RLO  = 9;
  localparam int C_ALU_ADD = 10;
  localparam int C_ARITH   = 11;
  localparam int C_SH_CAP  = 12;
  localparam int C_DEC_Q   = 13;
  localparam int C_LD_A    = 14;

  localparam logic [1:0] RHI_FROM_A   = 2'd0;
  localparam logic [1:0] RHI_FROM_SH  = 2'd1;
  localparam logic [1:0] RHI_FROM_ALU = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_TEST,
    S_ADD,
    S_SUB,
    S_SHIFT_CAP,
    S_SHIFT_LD,
    S_FINISH,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [14:0] c_q, c_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Word for the state being entered; last_iter suppresses the q decrement.
  function automatic logic [14:0] ctrl_word(input state_e s, input logic last_iter);
    logic [14:0] w;
    w = '0;
    case (s)
      S_LOAD: begin
        w[C_LD_Y]  = 1'b1;
        w[C_PRE_Q] = 1'b1;
        w[C_CLR_A] = 1'b1;
        w[C_LD_X]  = 1'b1;
      end
      S_INIT: begin
        w[5:4]      = RHI_FROM_A;
        w[C_LD_RHI] = 1'b1;
        w[C_LD_RLO] = 1'b1;
      end
      S_ADD: begin
        w[5:4]       = RHI_FROM_ALU;
        w[C_LD_RHI]  = 1'b1;
        w[C_ALU_ADD] = 1'b1;
      end
      S_SUB: begin
        w[5:4]      = RHI_FROM_ALU;
        w[C_LD_RHI] = 1'b1;
      end
      S_SHIFT_CAP: begin
        w[C_SH_CAP] = 1'b1;
        w[C_ARITH]  = 1'b1;
      end
      S_SHIFT_LD: begin
        w[5:4]       = RHI_FROM_SH;
        w[C_LD_RHI]  = 1'b1;
        w[C_RLO_SEL] = 1'b1;
        w[C_LD_RLO]  = 1'b1;
        w[C_ARITH]   = 1'b1;
        w[C_DEC_Q]   = !last_iter;
      end
      S_FINISH: begin
        w[C_LD_A]  = 1'b1;
        w[C_LD_X]  = 1'b1;
        w[C_X_SEL] = 1'b1;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD:      state_d = S_INIT;
      S_INIT:      state_d = S_TEST;
      S_TEST: begin
        if (zr) begin
          state_d = S_SHIFT_CAP;
        end else if (!zq) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SUB;
        end
      end
      S_ADD:       state_d = S_SHIFT_CAP;
      S_SUB:       state_d = S_SHIFT_CAP;
      S_SHIFT_CAP: state_d = S_SHIFT_LD;
      S_SHIFT_LD: begin
        if (zq) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_TEST;
        end
      end
      S_FINISH:    state_d = S_DONE;
      S_DONE: begin
`ifdef ROBS_CTRL_DONE_HOLD_EN
        if (!start) begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    c_d    = ctrl_word(state_d, zq);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign c    = c_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
